// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating-priority arbiter of I-cache refills and D-cache line reads/writes onto one synchronous memory port.
// Latency: Req to Done is MEM_LATENCY+LINE_WORDS+1 cycles; each read word appears the cycle after its beat, the last one with Done.
// Backpressure: none within a burst; requesters hold Req until Done, and the write side advances its word on DWready.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int LINE_WORDS  = 8,
   parameter int MEM_LATENCY = 4
) (
   input  logic                          clk,
   input  logic                          CpuRst,
   input  logic                          IReq,
   input  logic [ADDR_W-1:0]             IAddr,
   output logic                          IGnt,
   output logic                          IValid,
   output logic                          IDone,
   input  logic                          DReq,
   input  logic                          DWe,
   input  logic [ADDR_W-1:0]             DAddr,
   input  logic [DATA_W-1:0]             DWdata,
   output logic                          DWready,
   output logic                          DGnt,
   output logic                          DValid,
   output logic                          DDone,
   output logic [DATA_W-1:0]             RData,
   output logic [$clog2(LINE_WORDS)-1:0] RIdx,
   output logic                          MemEn,
   output logic                          MemWe,
   output logic [ADDR_W-1:0]             MemAddr,
   output logic [DATA_W-1:0]             MemWdata,
   input  logic [DATA_W-1:0]             MemRdata
);

   localparam int IDX_W    = $clog2(LINE_WORDS);
   localparam int OFF_W    = IDX_W + 2;
   localparam int LINE_W   = ADDR_W - OFF_W;
   localparam int LAT_LAST = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
   localparam int CNT_W    = (LAT_LAST > 0) ? $clog2(LAT_LAST + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  lat_cnt;
   logic [IDX_W-1:0]  beat;
   logic [IDX_W-1:0]  ridx;
   logic [LINE_W-1:0] line;
   logic              gnt_d;    // granted side: 1 = D, 0 = I
   logic              last_d;   // side that completed the previous transaction
   logic              we;
   logic              rvalid;
   logic              pick_d;
   logic              busy;
   logic              unused_offset;

   // On a tie the side that did not go last wins; a lone request always wins.
   assign pick_d = DReq && (!IReq || !last_d);

   // Sequencer: latch request at grant, count latency, walk the line, then one DONE cycle.
   always_ff @(posedge clk or posedge CpuRst) begin
      if (CpuRst) begin
         state   <= IDLE;
         lat_cnt <= '0;
         beat    <= '0;
         ridx    <= '0;
         line    <= '0;
         gnt_d   <= 1'b0;
         last_d  <= 1'b0;
         we      <= 1'b0;
         rvalid  <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (IReq || DReq) begin
                  gnt_d   <= pick_d;
                  we      <= pick_d && DWe;
                  line    <= pick_d ? DAddr[ADDR_W-1:OFF_W] : IAddr[ADDR_W-1:OFF_W];
                  lat_cnt <= '0;
                  beat    <= '0;
                  state   <= (MEM_LATENCY == 0) ? BURST : WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == CNT_W'(LAT_LAST))
                  state <= BURST;
               else
                  lat_cnt <= lat_cnt + CNT_W'(1);
            end
            BURST: begin
               // Read data for this beat comes back next cycle; tag it now.
               rvalid <= !we;
               ridx   <= beat;
               beat   <= beat + IDX_W'(1);
               if (beat == IDX_W'(LINE_WORDS - 1))
                  state <= DONE;
            end
            DONE: begin
               last_d <= gnt_d;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   assign IGnt  = busy && !gnt_d;
   assign DGnt  = busy && gnt_d;
   assign IDone = (state == DONE) && !gnt_d;
   assign DDone = (state == DONE) && gnt_d;

   // Word index replaces the offset bits, so the burst wraps inside the line.
   assign MemEn    = (state == BURST);
   assign MemWe    = MemEn && we;
   assign DWready  = MemEn && we;
   assign MemAddr  = {line, beat, 2'b00};
   assign MemWdata = (MemEn && we) ? DWdata : '0;

   // MemRdata is the memory's output register, so gating it with the
   // registered valid keeps the return path register-to-output.
   assign IValid = rvalid && !gnt_d;
   assign DValid = rvalid && gnt_d;
   assign RData  = rvalid ? MemRdata : '0;
   assign RIdx   = ridx;

   assign unused_offset = ^{IAddr[OFF_W-1:0], DAddr[OFF_W-1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int LW  = 8;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        CpuRst;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // default-configuration DUT
   logic        IReq, DReq, DWe;
   logic [31:0] IAddr, DAddr, DWdata, MemRdata;
   logic        IGnt, IValid, IDone, DWready, DGnt, DValid, DDone, MemEn, MemWe;
   logic [31:0] RData, MemAddr, MemWdata;
   logic [2:0]  RIdx;

   // zero-latency, four-word DUT
   logic        b_IReq, b_DReq, b_DWe;
   logic [31:0] b_IAddr, b_DAddr, b_DWdata, b_MemRdata;
   logic        b_IGnt, b_IValid, b_IDone, b_DWready, b_DGnt, b_DValid, b_DDone, b_MemEn, b_MemWe;
   logic [31:0] b_RData, b_MemAddr, b_MemWdata;
   logic [1:0]  b_RIdx;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .CpuRst(CpuRst),
      .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IDone(IDone),
      .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DWready(DWready),
      .DGnt(DGnt), .DValid(DValid), .DDone(DDone),
      .RData(RData), .RIdx(RIdx),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemRdata(MemRdata)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .MEM_LATENCY(0)) dut_b (
      .clk(clk), .CpuRst(CpuRst),
      .IReq(b_IReq), .IAddr(b_IAddr), .IGnt(b_IGnt), .IValid(b_IValid), .IDone(b_IDone),
      .DReq(b_DReq), .DWe(b_DWe), .DAddr(b_DAddr), .DWdata(b_DWdata), .DWready(b_DWready),
      .DGnt(b_DGnt), .DValid(b_DValid), .DDone(b_DDone),
      .RData(b_RData), .RIdx(b_RIdx),
      .MemEn(b_MemEn), .MemWe(b_MemWe), .MemAddr(b_MemAddr), .MemWdata(b_MemWdata), .MemRdata(b_MemRdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   // Synchronous read memories: data is available the cycle after the read beat.
   always @(posedge clk) if (MemEn && !MemWe) MemRdata <= memf(MemAddr);
   always @(posedge clk) if (b_MemEn && !b_MemWe) b_MemRdata <= memf(b_MemAddr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: a granted transaction is a fixed schedule measured in
   // cycles since grant (t); outputs follow from t by plain arithmetic.
   initial begin : model
      bit          busy, md, mwe, mlast, beat_on, vld_on, done_on;
      int          t, k, j;
      logic [31:0] mbase, lbase;
      busy = 0; md = 0; mwe = 0; mlast = 0; t = 0; mbase = 0;
      forever begin
         @(negedge clk);
         if (CpuRst) begin
            chk("r_ignt", IGnt, 0);     chk("r_dgnt", DGnt, 0);
            chk("r_ivld", IValid, 0);   chk("r_dvld", DValid, 0);
            chk("r_idone", IDone, 0);   chk("r_ddone", DDone, 0);
            chk("r_memen", MemEn, 0);   chk("r_memwe", MemWe, 0);
            chk("r_dwready", DWready, 0);
            chk("r_addr", MemAddr, 0);  chk("r_wdata", MemWdata, 0);
            chk("r_rdata", RData, 0);   chk("r_ridx", RIdx, 0);
            busy = 0; mlast = 0;
         end else begin
            beat_on = busy && (t >= LAT + 1) && (t <= LAT + LW);
            vld_on  = busy && !mwe && (t >= LAT + 2);
            done_on = busy && (t == LAT + LW + 1);
            lbase   = mbase & ~32'(LW * 4 - 1);
            chk("m_ignt", IGnt, busy && !md);
            chk("m_dgnt", DGnt, busy && md);
            chk("m_memen", MemEn, beat_on);
            chk("m_memwe", MemWe, beat_on && mwe);
            chk("m_dwready", DWready, beat_on && mwe);
            if (beat_on) begin
               k = t - LAT - 1;
               chk("m_addr", MemAddr, lbase + 32'(k * 4));
               if (mwe) chk("m_wdata", MemWdata, DWdata);
            end
            chk("m_ivld", IValid, vld_on && !md);
            chk("m_dvld", DValid, vld_on && md);
            if (vld_on) begin
               j = t - LAT - 2;
               chk("m_ridx", RIdx, 32'(j));
               chk("m_rdata", RData, memf(lbase + 32'(j * 4)));
            end
            chk("m_idone", IDone, done_on && !md);
            chk("m_ddone", DDone, done_on && md);
            if (busy) begin
               if (done_on) begin busy = 0; mlast = md; end
               else t++;
            end else if (IReq || DReq) begin
               md    = DReq && (!IReq || !mlast);
               mwe   = md && DWe;
               mbase = md ? DAddr : IAddr;
               busy  = 1;
               t     = 1;
            end
         end
      end
   end

   initial begin : wdata_drv
      DWdata = 0;
      forever begin
         @(posedge clk); #1;
         DWdata = $urandom;
      end
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bench did not finish");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Both sides request together; D should win when I went last.
   task automatic tie_pair();
      IReq = 1; DReq = 1; DWe = 0; IAddr = 32'h3000; DAddr = 32'h4000;
      for (int c = 0; c <= 28; c++) begin
         @(negedge clk);
         if (c == 1) begin chk("tie_dgnt", DGnt, 1); chk("tie_ignt_wait", IGnt, 0); end
         if (c == 13) chk("tie_ddone", DDone, 1);
         if (c == 14) chk("tie_gap", IGnt | DGnt, 0);
         if (c == 15) chk("tie_ignt", IGnt, 1);
         if (c == 27) chk("tie_idone", IDone, 1);
         tick();
         if (c == 13) DReq = 0;
         if (c == 27) IReq = 0;
      end
   endtask

   // Address/direction/request changed after grant must not disturb the burst.
   task automatic mid_change(input bit sd, input logic [31:0] base);
      int dn;
      dn = 0;
      if (sd) begin DReq = 1; DWe = 0; DAddr = base; end
      else    begin IReq = 1; IAddr = base; end
      for (int c = 0; c <= 15; c++) begin
         @(negedge clk);
         if (c >= 5 && c <= 12) begin
            chk("mc_addr", MemAddr, base + 32'(4 * (c - 5)));
            chk("mc_we", MemWe, 0);
         end
         if (c == 13) chk("mc_vld", sd ? DValid : IValid, 1);
         dn += sd ? int'(DDone) : int'(IDone);
         tick();
         if (c == 2) begin
            IAddr = 32'hABCD_0040; DAddr = 32'h7777_0020; DWe = 1; IReq = 0; DReq = 0;
         end
      end
      chk("mc_done_cnt", dn, 1);
      DWe = 0;
   endtask

   task automatic i_agent(input int n);
      for (int x = 0; x < n; x++) begin
         int w;
         repeat ($urandom_range(0, 5)) tick();
         IReq = 1; IAddr = $urandom;
         for (w = 0; w < 80; w++) begin
            @(negedge clk);
            if (IDone) break;
            if (IGnt && $urandom_range(0, 9) == 0) begin
               tick();
               IAddr = $urandom; IReq = 1'($urandom_range(0, 1));
            end
         end
         chk("i_timeout", 32'(w < 80), 1);
         tick();
         IReq = 0;
      end
   endtask

   task automatic d_agent(input int n);
      for (int x = 0; x < n; x++) begin
         int w;
         repeat ($urandom_range(0, 5)) tick();
         DReq = 1; DWe = 1'($urandom_range(0, 1)); DAddr = $urandom;
         for (w = 0; w < 80; w++) begin
            @(negedge clk);
            if (DDone) break;
            if (DGnt && $urandom_range(0, 9) == 0) begin
               tick();
               DAddr = $urandom; DWe = ~DWe; DReq = 1'($urandom_range(0, 1));
            end
         end
         chk("d_timeout", 32'(w < 80), 1);
         tick();
         DReq = 0; DWe = 0;
      end
   endtask

   initial begin : main
      CpuRst = 1;
      IReq = 0; DReq = 0; DWe = 0; IAddr = 0; DAddr = 0;
      b_IReq = 0; b_DReq = 0; b_DWe = 0; b_IAddr = 0; b_DAddr = 0; b_DWdata = 0;
      repeat (3) tick();
      chk("rst_memen", MemEn, 0);
      chk("rst_gnt", {IGnt, DGnt}, 0);
      chk("rst_rdata", RData, 0);
      chk("rst_b_memen", b_MemEn, 0);
      CpuRst = 0;

      tie_pair();
      tie_pair();

      // I-side line read, offset bits of the request ignored
      IReq = 1; IAddr = 32'h0000_1014;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         chk("i_gnt", IGnt, c >= 1 && c <= 13);
         chk("i_memen", MemEn, c >= 5 && c <= 12);
         if (c >= 5 && c <= 12) chk("i_addr", MemAddr, 32'h1000 + 32'(4 * (c - 5)));
         chk("i_vld", IValid, c >= 6 && c <= 13);
         if (c >= 6) chk("i_ridx", RIdx, 32'(c - 6));
         if (c == 6) chk("i_rdata0", RData, memf(32'h1000));
         chk("i_done", IDone, c == 13);
         tick();
         if (c == 13) IReq = 0;
      end

      // D-side line write-back
      DReq = 1; DWe = 1; DAddr = 32'h2000;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         chk("w_gnt", DGnt, c >= 1 && c <= 13);
         chk("w_dwready", DWready, c >= 5 && c <= 12);
         chk("w_memwe", MemWe, c >= 5 && c <= 12);
         if (c >= 5 && c <= 12) begin
            chk("w_wdata", MemWdata, DWdata);
            chk("w_addr", MemAddr, 32'h2000 + 32'(4 * (c - 5)));
         end
         chk("w_dvld", DValid, 0);
         chk("w_done", DDone, c == 13);
         tick();
         if (c == 13) begin DReq = 0; DWe = 0; end
      end

      mid_change(0, 32'h5000);
      mid_change(1, 32'h6000);

      fork
         i_agent(30);
         d_agent(30);
      join
      repeat (2) tick();

      // Reset in the middle of a burst, then a fresh transaction
      IReq = 1; IAddr = 32'h8000;
      repeat (8) tick();
      chk("rb_memen_pre", MemEn, 1);
      chk("rb_addr_pre", MemAddr, 32'h800C);
      chk("rb_vld_pre", IValid, 1);
      #2 CpuRst = 1;
      #1;
      chk("rb_memen", MemEn, 0);
      chk("rb_ignt", IGnt, 0);
      chk("rb_ivld", IValid, 0);
      chk("rb_rdata", RData, 0);
      tick();
      CpuRst = 0;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) chk("ra_ignt", IGnt, 1);
         if (c == 5) begin chk("ra_memen", MemEn, 1); chk("ra_addr", MemAddr, 32'h8000); end
         if (c == 13) chk("ra_idone", IDone, 1);
         tick();
         if (c == 13) IReq = 0;
      end

      // Zero latency, four-word line, wrap at the top of the address space
      b_IReq = 1; b_IAddr = 32'hFFFF_FFFA;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         chk("b_gnt", b_IGnt, c >= 1 && c <= 5);
         chk("b_memen", b_MemEn, c >= 1 && c <= 4);
         if (c >= 1 && c <= 4) chk("b_addr", b_MemAddr, 32'hFFFF_FFF0 + 32'(4 * (c - 1)));
         chk("b_vld", b_IValid, c >= 2 && c <= 5);
         if (c >= 2 && c <= 5) begin
            chk("b_ridx", b_RIdx, 32'(c - 2));
            chk("b_rdata", b_RData, memf(32'hFFFF_FFF0 + 32'(4 * (c - 2))));
         end
         chk("b_done", b_IDone, c == 5);
         tick();
         if (c == 5) b_IReq = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
